// File: rtl/ram_responder_pkg.sv
// ram_responder_pkg: shared RAM bus widths and responder state encoding.
package ram_responder_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;
endpackage

// File: rtl/ram_responder_core.sv
// ram_responder_core: DEPTH x DATA_W array, sync write port, registered read port holding when re=0.
module ram_responder_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= r_mem[raddr];
  end
endmodule

// File: rtl/ram_responder.sv
// ram_responder: memory-side RAM bus endpoint with post-reset clear, conflict flag and request counters.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                CNT_W       = 8,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_rd,
  input  logic              ram_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] ram_data_in,
  output logic [DATA_W-1:0] ram_data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              err_conflict,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);
  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_rd_valid, r_busy, r_err, r_rd_prev, r_wr_prev;
  logic [CNT_W-1:0]  r_rd_count, r_wr_count;
  logic              w_ready, w_we, w_re, w_rd_inc, w_wr_inc;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  assign w_ready  = r_state == ST_READY;
  // Clearing owns the write port; a conflicting read is dropped in favour of the write.
  assign w_we     = !rst && (w_ready ? ram_wr : 1'b1);
  assign w_waddr  = w_ready ? addr : r_clr_ptr;
  assign w_wdata  = w_ready ? ram_data_in : CLEAR_VALUE;
  assign w_re     = !rst && w_ready && ram_rd && !ram_wr;
  assign w_rd_inc = w_ready && ram_rd && !r_rd_prev && !ram_wr;
  assign w_wr_inc = w_ready && ram_wr && !r_wr_prev;
  ram_responder_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_core (
    .clk(clk), .rst(rst), .we(w_we), .waddr(w_waddr), .wdata(w_wdata),
    .re(w_re), .raddr(addr), .rdata(ram_data_out)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_CLEAR;
      r_clr_ptr  <= '0;
      r_rd_valid <= 1'b0;
      r_busy     <= 1'b1;
      r_err      <= 1'b0;
      r_rd_count <= '0;
      r_wr_count <= '0;
      r_rd_prev  <= 1'b0;
      r_wr_prev  <= 1'b0;
    end else begin
      r_rd_prev <= ram_rd;
      r_wr_prev <= ram_wr;
      if (!w_ready) begin
        r_clr_ptr <= r_clr_ptr + 1'b1;
        if (&r_clr_ptr) begin
          r_state <= ST_READY;
          r_busy  <= 1'b0;
        end
      end else begin
        r_rd_valid <= w_re;
        if (ram_rd && ram_wr) r_err <= 1'b1;
        if (w_rd_inc && !(&r_rd_count)) r_rd_count <= r_rd_count + 1'b1;
        if (w_wr_inc && !(&r_wr_count)) r_wr_count <= r_wr_count + 1'b1;
      end
    end
  end
  assign rd_valid     = r_rd_valid;
  assign busy         = r_busy;
  assign err_conflict = r_err;
  assign rd_count     = r_rd_count;
  assign wr_count     = r_wr_count;
endmodule
